// File: rtl/mac_seq_controller.sv
// Sequencer for the multiply-accumulate datapath: length, handshakes, multiplier latency, abort.
// Build option: define MAC_STALL_CNT_EN to add the saturating stall_cnt output.
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// CLR   | one-cycle accumulator clear (skipped in accumulate-continue mode)
// LOAD  | ready for an operand pair, stalls while in_valid is low
// MULT  | multiplier in flight for MULT_LAT cycles
// ACC   | accumulate product into sum, advance idx or finish
// DONE  | one-cycle completion pulse
module mac_seq_controller #(
    parameter int LEN_W    = 8,
    parameter int MULT_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             accum,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_ld,
    output logic             y_ld,
    output logic             sum_ld,
    output logic             sum_clr,
    output logic             mult_sel,
    output logic [LEN_W-1:0] idx,
    output logic             busy,
    output logic             done
`ifdef MAC_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        CLR  = 3'b001,
        LOAD = 3'b010,
        MULT = 3'b011,
        ACC  = 3'b101,
        DONE = 3'b110
    } state_t;

    localparam logic [3:0]       MULT_RELOAD = 4'(MULT_LAT - 1);
    localparam logic [LEN_W-1:0] IDX_ONE     = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_nxt;
    logic [LEN_W-1:0] idx_nxt;
    logic [3:0]       mult_cnt;
    logic [3:0]       cnt_nxt;
    logic             last_elem;
    logic             start_acc;

    assign last_elem = (idx == (len_q - IDX_ONE));
    assign start_acc = (state == IDLE) && start;

    // Operand strobes are the only Mealy outputs so the pair is captured in the same cycle it is offered.
    assign x_ld = in_valid & in_ready;
    assign y_ld = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len_q;
        cnt_nxt   = mult_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt = len;
                    idx_nxt = '0;
                    if (len == '0)
                        state_nxt = DONE;
                    else if (accum)
                        state_nxt = LOAD;
                    else
                        state_nxt = CLR;
                end
            end
            CLR: state_nxt = LOAD;
            LOAD: begin
                if (in_valid) begin
                    state_nxt = MULT;
                    cnt_nxt   = MULT_RELOAD;
                end
            end
            MULT: begin
                if (mult_cnt == '0)
                    state_nxt = ACC;
                else
                    cnt_nxt = mult_cnt - 4'd1;
            end
            ACC: begin
                if (last_elem) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + IDX_ONE;
                    state_nxt = LOAD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end
    end

    // Moore strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            len_q    <= '0;
            mult_cnt <= '0;
            in_ready <= 1'b0;
            sum_ld   <= 1'b0;
            sum_clr  <= 1'b0;
            mult_sel <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            len_q    <= len_nxt;
            mult_cnt <= cnt_nxt;
            in_ready <= (state_nxt == LOAD);
            sum_ld   <= (state_nxt == ACC);
            sum_clr  <= (state_nxt == CLR);
            mult_sel <= (state_nxt == MULT) || (state_nxt == ACC);
            busy     <= (state_nxt == CLR) || (state_nxt == LOAD) ||
                        (state_nxt == MULT) || (state_nxt == ACC);
            done     <= (state_nxt == DONE);
        end
    end

`ifdef MAC_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if (start_acc)
            stall_cnt <= '0;
        else if ((state == LOAD) && !in_valid && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_mac_seq_controller.sv
// Self-checking bench for mac_seq_controller: two instances (MULT_LAT 1 and 3) against an
// expected-trace model built from the per-element timing rules.
module tb_mac_seq_controller;

    localparam int LEN_W = 8;

    typedef int iq_t[$];

    typedef struct {
        bit               st;
        bit               ab;
        bit               rs;
        bit               iv;
        logic [LEN_W-1:0] ln;
        bit               rdy;
        bit               xy;
        bit               sld;
        bit               clr;
        bit               msel;
        bit               bsy;
        bit               dn;
        logic [LEN_W-1:0] ix;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset[2];
    logic             start[2];
    logic             accum[2];
    logic             abort[2];
    logic             in_valid[2];
    logic [LEN_W-1:0] len[2];
    logic             in_ready[2];
    logic             x_ld[2];
    logic             y_ld[2];
    logic             sum_ld[2];
    logic             sum_clr[2];
    logic             mult_sel[2];
    logic             busy[2];
    logic             done[2];
    logic [LEN_W-1:0] idx[2];
`ifdef MAC_STALL_CNT_EN
    logic [15:0]      stall_cnt[2];
`endif

    mac_seq_controller #(.LEN_W(LEN_W), .MULT_LAT(1)) dut_a (
        .clk(clk), .reset(reset[0]), .start(start[0]), .len(len[0]), .accum(accum[0]),
        .abort(abort[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .x_ld(x_ld[0]),
        .y_ld(y_ld[0]), .sum_ld(sum_ld[0]), .sum_clr(sum_clr[0]), .mult_sel(mult_sel[0]),
        .idx(idx[0]), .busy(busy[0]), .done(done[0])
`ifdef MAC_STALL_CNT_EN
        , .stall_cnt(stall_cnt[0])
`endif
    );

    mac_seq_controller #(.LEN_W(LEN_W), .MULT_LAT(3)) dut_b (
        .clk(clk), .reset(reset[1]), .start(start[1]), .len(len[1]), .accum(accum[1]),
        .abort(abort[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .x_ld(x_ld[1]),
        .y_ld(y_ld[1]), .sum_ld(sum_ld[1]), .sum_clr(sum_clr[1]), .mult_sel(mult_sel[1]),
        .idx(idx[1]), .busy(busy[1]), .done(done[1])
`ifdef MAC_STALL_CNT_EN
        , .stall_cnt(stall_cnt[1])
`endif
    );

    ent_t             tr[$];
    int               npass = 0;
    int               ntotal = 0;
    logic [LEN_W-1:0] idle_idx[2];
    int               exp_stall[2];

    function automatic int lat_of(int d);
        return (d != 0) ? 3 : 1;
    endfunction

    function automatic logic [15:0] obs(int d);
        return {in_ready[d], x_ld[d], y_ld[d], sum_ld[d], sum_clr[d], mult_sel[d],
                busy[d], done[d], idx[d]};
    endfunction

    function automatic logic [15:0] expv(ent_t e);
        return {e.rdy, e.xy, e.xy, e.sld, e.clr, e.msel, e.bsy, e.dn, e.ix};
    endfunction

    function automatic ent_t base(logic [LEN_W-1:0] ix);
        ent_t e;
        e.st = ($urandom_range(3) == 0);
        e.ab = 1'b0;
        e.rs = 1'b0;
        e.iv = 1'($urandom);
        e.ln = LEN_W'($urandom);
        e.rdy = 1'b0; e.xy = 1'b0; e.sld = 1'b0; e.clr = 1'b0;
        e.msel = 1'b0; e.bsy = 1'b0; e.dn = 1'b0;
        e.ix = ix;
        return e;
    endfunction

    function automatic iq_t rand_stalls(int n, int mx);
        iq_t q;
        for (int k = 0; k < n; k++) q.push_back((mx > 0) ? int'($urandom_range(mx)) : 0);
        return q;
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] x);
        ntotal++;
        assert (o === x) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    endtask

    // Expected trace of one operation, starting with the IDLE cycle in which start is accepted.
    task automatic build(int d, int n, bit acc, iq_t stl, bit chain);
        ent_t e;
        tr.delete();
        e = base(idle_idx[d]);
        e.st = 1'b1;
        e.ln = LEN_W'(n);
        tr.push_back(e);
        if (n == 0) begin
            e = base('0); e.dn = 1'b1; e.st = chain;
            tr.push_back(e);
            return;
        end
        if (!acc) begin
            e = base('0); e.clr = 1'b1; e.bsy = 1'b1;
            tr.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < stl[k]; s++) begin
                e = base(LEN_W'(k)); e.rdy = 1'b1; e.bsy = 1'b1; e.iv = 1'b0;
                tr.push_back(e);
            end
            e = base(LEN_W'(k)); e.rdy = 1'b1; e.bsy = 1'b1; e.iv = 1'b1; e.xy = 1'b1;
            tr.push_back(e);
            for (int l = 0; l < lat_of(d); l++) begin
                e = base(LEN_W'(k)); e.msel = 1'b1; e.bsy = 1'b1;
                tr.push_back(e);
            end
            e = base(LEN_W'(k)); e.msel = 1'b1; e.sld = 1'b1; e.bsy = 1'b1;
            tr.push_back(e);
        end
        e = base(LEN_W'(n - 1)); e.dn = 1'b1; e.st = chain;
        tr.push_back(e);
    endtask

    task automatic play(int d, string tag, output int done_at);
        done_at = -1;
        foreach (tr[i]) begin
            @(negedge clk);
            start[d]    = tr[i].st;
            abort[d]    = tr[i].ab;
            reset[d]    = ~tr[i].rs;
            in_valid[d] = tr[i].iv;
            len[d]      = tr[i].ln;
            accum[d]    = (i == 0) ? accum[d] : 1'($urandom);
            #1;
            chk($sformatf("%s_c%0d", tag, i), 32'(obs(d)), 32'(expv(tr[i])));
            if (done[d] === 1'b1 && done_at < 0) done_at = i;
        end
    endtask

    task automatic idle_check(int d, int ncyc, string tag);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            start[d]    = 1'b0;
            abort[d]    = 1'b0;
            reset[d]    = 1'b1;
            in_valid[d] = 1'($urandom);
            len[d]      = LEN_W'($urandom);
            #1;
            chk({tag, "_idle"}, 32'(obs(d)), {16'h0, 8'h0, idle_idx[d]});
        end
`ifdef MAC_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, 32'(stall_cnt[d]), 32'(exp_stall[d]));
`endif
    endtask

    // kmode: 0 none, 1 abort in first MULT of element 1, 2 reset in first ACC
    task automatic run_op(int d, int n, bit acc, iq_t stl, int kmode, bit chain, string tag);
        int   done_at;
        int   k;
        int   nst;
        int   exp_done;
        bit   killed;
        ent_t e;
        build(d, n, acc, stl, chain);
        accum[d] = acc;
        k = -1;
        if (kmode != 0) begin
            foreach (tr[i]) begin
                if (k < 0 && kmode == 1 && tr[i].msel && !tr[i].sld && tr[i].ix == 1) k = i;
                if (k < 0 && kmode == 2 && tr[i].sld) k = i;
            end
        end
        killed = (k >= 0);
        if (killed) begin
            while (tr.size() > k + 1) void'(tr.pop_back());
            if (kmode == 1) tr[k].ab = 1'b1;
            else            tr[k].rs = 1'b1;
            e = base('0);
            e.st = 1'b0;
            tr.push_back(e);
        end
        nst = 0;
        foreach (tr[i]) if (tr[i].rdy && !tr[i].iv) nst++;
        play(d, tag, done_at);
        if (killed) begin
            chk({tag, "_no_done"}, 32'(done_at), 32'(-1));
            idle_idx[d]  = '0;
            exp_stall[d] = (kmode == 2) ? 0 : nst;
        end else begin
            exp_done = 1;
            if (n > 0) begin
                exp_done = (acc ? 1 : 2) + n * (lat_of(d) + 2);
                foreach (stl[j]) exp_done += stl[j];
            end
            chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
            idle_idx[d]  = (n == 0) ? '0 : LEN_W'(n - 1);
            exp_stall[d] = nst;
        end
        if (!chain) idle_check(d, 2, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iq_t q;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0; start[d] = 1'b0; accum[d] = 1'b0; abort[d] = 1'b0;
            in_valid[d] = 1'b0; len[d] = '0;
            idle_idx[d] = '0; exp_stall[d] = 0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_state", 32'(obs(d)), 32'h0);
`ifdef MAC_STALL_CNT_EN
            chk("reset_stall_cnt", 32'(stall_cnt[d]), 32'h0);
`endif
        end
        reset[0] = 1'b1;
        reset[1] = 1'b1;

        run_op(0, 3, 1'b0, rand_stalls(3, 0), 0, 1'b0, "basic");
        q = '{2, 0};
        run_op(1, 2, 1'b0, q, 0, 1'b0, "stall_lat3");
        q.delete();
        run_op(0, 0, 1'b0, q, 0, 1'b0, "len_zero");
        run_op(1, 0, 1'b1, q, 0, 1'b0, "len_zero_b");
        run_op(0, 2, 1'b1, rand_stalls(2, 0), 0, 1'b0, "accum");
        run_op(1, 4, 1'b0, rand_stalls(4, 1), 1, 1'b0, "abort");
        run_op(0, 3, 1'b0, rand_stalls(3, 1), 2, 1'b0, "reset_acc");
        run_op(0, 2, 1'b0, rand_stalls(2, 0), 0, 1'b1, "chain_a");
        run_op(0, 1, 1'b1, rand_stalls(1, 0), 0, 1'b0, "chain_b");
        run_op(0, 255, 1'b0, rand_stalls(255, 1), 0, 1'b0, "len_max");

        for (int r = 0; r < 16; r++) begin
            int d;
            int n;
            int km;
            d  = int'($urandom_range(1));
            n  = int'($urandom_range(12));
            km = ($urandom_range(4) == 0) ? 1 : 0;
            run_op(d, n, 1'($urandom), rand_stalls(n, 3), km, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/mac_seq_controller.md
Name: mac_seq_controller

Overview:
- Parametrised sequencer for the multiply-accumulate (dot-product) datapath. Successor to the fixed five-state x/y/sum controller.
- Adds a programmable vector length, a start/done handshake, an operand valid/ready handshake, a configurable multiplier latency, accumulate-continue mode and abort.
- Drives x_ld, y_ld, sum_ld, sum_clr and mult_sel of the existing datapath registers and multiplier mux.

Parameters:
LEN_W, 8, width of the vector-length input and the element index; maximum length is 2^LEN_W-1
MULT_LAT, 1, cycles spent in MULT per element (pipelined multiplier depth); legal range 1..15

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
len  input  LEN_W  number of element pairs; latched when start is accepted
accum  input  1  1 = keep the existing sum (no clear); latched with start
abort  input  1  synchronous cancel of the current operation
in_valid  input  1  operand pair (x,y) available at the datapath inputs
in_ready  output  1  controller is ready to load an operand pair
x_ld  output  1  load the x register
y_ld  output  1  load the y register
sum_ld  output  1  load the accumulator with sum+product
sum_clr  output  1  clear the accumulator
mult_sel  output  1  selects the multiplier result into the adder path
idx  output  LEN_W  index of the current element, starting at 0
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low: reset=0 at a rising edge forces IDLE.
- Values in reset: idx=0, len_q=0, and every output is 0.
- State encoding: IDLE=3'b000, CLR=3'b001, LOAD=3'b010, MULT=3'b011, ACC=3'b101, DONE=3'b110. Unused encodings go to IDLE.
- Priority: reset > abort > normal transitions.
- IDLE:
  - busy=0.
  - start=1 and len!=0: latch len and accum, set idx=0, then go to CLR if accum=0, else LOAD.
  - start=1 and len=0: go to DONE. No clear, no loads, no sum_ld.
- CLR: sum_clr=1 for exactly one cycle, then LOAD.
- LOAD:
  - in_ready=1.
  - x_ld=y_ld=in_valid&in_ready (combinational).
  - in_valid=1: go to MULT. in_valid=0: stay in LOAD (stall).
- MULT:
  - mult_sel=1.
  - Stays MULT_LAT cycles, using an internal counter that is reloaded on entry. Then ACC.
- ACC:
  - mult_sel=1 and sum_ld=1 for one cycle.
  - idx==len_q-1: go to DONE. Otherwise idx increments by 1 and the state returns to LOAD.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in CLR, LOAD, MULT and ACC.
- All outputs except x_ld and y_ld are Moore (decoded from state).
- start is ignored outside IDLE. A start that is high in the same cycle as DONE is not accepted. It is accepted on the following IDLE cycle if it is still high.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, idx=0, no done pulse.
  - Outputs derived from the current state remain valid during the abort cycle.
  - x_ld and y_ld are still gated by in_valid in that cycle.
- Timing: per element = 1 (LOAD, no stall) + MULT_LAT + 1 (ACC). Start accepted at cycle 0 with accum=0 and no stalls gives done at cycle 2+N*(MULT_LAT+2).
- len=2^LEN_W-1 must complete without wrapping idx. The last idx value is len-1.

Optional Feature:
- Macro name: MAC_STALL_CNT_EN.
- When defined:
  - Extra output port stall_cnt [15:0] is present.
  - It counts the LOAD cycles with in_valid=0 and saturates at 16'hFFFF.
  - It is cleared when start is accepted and by reset, and holds its value in IDLE and DONE.
- When undefined: no port and no logic.

Test Plan:
- Basic run: MULT_LAT=1, len=3, accum=0, in_valid=1 constantly, start at cycle 0 -> sum_clr at cycle 1, three x_ld/y_ld pulses, three sum_ld pulses, idx 0→1→2, done at cycle 11, busy low in cycle 11.
- Stalls plus latency: MULT_LAT=3, len=2, in_valid low for 2 cycles in the first LOAD -> 2 extra LOAD cycles, mult_sel high 3+1 cycles per element, done at cycle 2+2*5+2=14, and stall_cnt=2 when MAC_STALL_CNT_EN is defined.
- Zero length and accumulate mode:
  - len=0 -> DONE the next cycle with no sum_clr, x_ld or sum_ld.
  - len=2, accum=1 -> no sum_clr, first LOAD at cycle 1.
- Abort and reset mid-operation:
  - abort asserted in the second MULT of len=4 -> IDLE next cycle, idx=0, done never pulses.
  - reset=0 in ACC -> every output 0 the next cycle.
- Back-to-back starts:
  - start held high through DONE -> the second operation is accepted one cycle after DONE.
  - start pulsed while busy -> ignored.
  - len=255 with LEN_W=8 -> idx reaches 254, done asserted, no wrap.
